fighter_ctrl: RTL and testbench
===============================

Name: fighter_ctrl

Overview:
- Parametrised per-player action controller. Successor to the fixed-timer player block.
- Converts debounced button levels plus game-side hit/KO events into a one-hot action state (for sprite selection) and movement/attack requests to the game engine.
- Adds configurable action durations, HURT (hitstun) and KO states, and a one-deep attack buffer during jumps.
- Sits between the button debouncers and the game/collision logic; one instance per player.

Parameters:
- CNT_W, 24, width of the duration/cooldown counters.
- JUMP_TICKS, 24'd5000000, cycles a jump lasts.
- PUNCH_TICKS, 24'd1250000, cycles the PUNCH state is held.
- COOLDOWN_TICKS, 24'd2500000, minimum cycles between successive attack_request pulses.
- HITSTUN_TICKS, 24'd2000000, cycles spent in HURT per hit.
- BUFFER_EN, 1, 1 = attack pressed in the second half of a jump fires on landing.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- player_id  in  1  0/1; sets initial facing (0 = right).
- left_btn, right_btn, up_btn, down_btn, attack_btn, shield_btn  in  1 each  debounced button levels.
- hit_in  in  1  one-cycle pulse from game: this player was struck.
- health_zero  in  1  level from game: health has reached 0.
- attack_request  out  1  one-cycle pulse: attack launched.
- jump_request  out  1  one-cycle pulse: jump started.
- left_request, right_request  out  1 each  level: move request this cycle.
- action  out  9  {facing, one-hot[7:0]}; bit 8 = 1 means facing left.
- busy  out  1  high in JUMP, PUNCH, HURT or KO.

Behaviour:
- All outputs registered. Reset values:
  - action = {player_id, STAND}
  - all requests = 0, busy = 0
  - counters = 0, buffer flag cleared.
- One-hot codes, bit0..bit7: WALK, CROUCH, SHIELD, JUMP, PUNCH, STAND, HURT, KO.
- Facing: right_btn → 0, else left_btn → 1, else hold. Frozen in HURT and KO.
- Priority, evaluated each cycle from the current state:
  1. health_zero → KO. KO is sticky until reset and ignores all inputs.
  2. hit_in while state ≠ SHIELD → HURT; load dur_cnt = HITSTUN_TICKS-1. A hit while already in HURT reloads the counter. hit_in while in SHIELD is ignored.
  3. HURT → STAND when dur_cnt == 0.
  4. JUMP → STAND when dur_cnt == 0.
  5. PUNCH → STAND when dur_cnt == 0.
  6. Idle states (STAND, WALK, CROUCH, SHIELD): down → CROUCH; else left/right → WALK; else shield → SHIELD; else up → JUMP; else attack → PUNCH; else STAND.
- Entering JUMP:
  - load dur_cnt = JUMP_TICKS-1
  - jump_request = 1 for the next cycle only.
- Entering PUNCH is allowed only when cd_cnt == 0. If cd_cnt ≠ 0, the attack press is ignored and the state stays STAND.
- On PUNCH entry:
  - attack_request = 1 for exactly one cycle
  - load dur_cnt = PUNCH_TICKS-1
  - load cd_cnt = COOLDOWN_TICKS-1.
- Holding attack_btn does not re-trigger. A new PUNCH needs a return to an idle state and cd_cnt == 0.
- Counters:
  - dur_cnt decrements by 1 every cycle while nonzero; saturates at 0, no wrap.
  - cd_cnt decrements independently in every state, including HURT.
- left_request/right_request:
  - asserted in WALK and in JUMP (air control) for the held direction
  - if both buttons are held, right wins
  - 0 in CROUCH, SHIELD, PUNCH, HURT, KO.
- Attack buffer (BUFFER_EN = 1):
  - attack_btn seen while in JUMP with dur_cnt < JUMP_TICKS/2 sets buf.
  - On landing, if buf is set and cd_cnt == 0, go JUMP → PUNCH directly; buf clears.
  - buf also clears on entering HURT or KO.
- Simultaneous hit_in and landing: HURT wins.
- Simultaneous hit_in and health_zero: KO wins.
- Reset asserted mid-action returns to the reset state on that same edge.

Decomposition:
- fighter_pkg: one-hot state constants, FACE_RIGHT/FACE_LEFT, ACTION_W = 9.
- Sub-module tick_counter (CNT_W): load, load_val, decrement-to-zero, zero flag.
- Instantiate tick_counter twice: dur_cnt and cd_cnt.

Test Plan:
- Params JUMP_TICKS=8, PUNCH_TICKS=4, COOLDOWN_TICKS=10, HITSTUN_TICKS=6; reset low 2 cycles → action = {player_id,STAND}, all requests 0.
- up_btn for 1 cycle → jump_request high exactly 1 cycle; action JUMP for 8 cycles, then STAND; busy high throughout.
- attack_btn held for 30 cycles → attack_request pulses once; PUNCH lasts 4 cycles, then STAND; no second pulse while held.
- Release attack, then press again 2 cycles after PUNCH ends (cd_cnt ≠ 0) → no pulse. Press after cd_cnt reaches 0 → pulse.
- Jump, press attack at jump cycle 6 → on landing, PUNCH with attack_request immediately.
- hit_in during WALK → HURT for 6 cycles and move requests drop; hit_in at HURT cycle 3 → stays HURT 6 more cycles. hit_in during SHIELD → no state change. health_zero → KO held despite any buttons until reset.

Source files
------------

// File: rtl/fighter_pkg.sv
// fighter_pkg
//   Shared constants for the per-player action controller: the one-hot
//   action codes used for sprite selection, facing encodings, the width of
//   the action bus and a helper that classifies states as "busy".
package fighter_pkg;

  localparam int ACTION_W = 9;
  localparam int STATE_W  = 8;

  // One-hot action codes; bit position is the sprite index.
  localparam logic [STATE_W-1:0] ST_WALK   = 8'b0000_0001;
  localparam logic [STATE_W-1:0] ST_CROUCH = 8'b0000_0010;
  localparam logic [STATE_W-1:0] ST_SHIELD = 8'b0000_0100;
  localparam logic [STATE_W-1:0] ST_JUMP   = 8'b0000_1000;
  localparam logic [STATE_W-1:0] ST_PUNCH  = 8'b0001_0000;
  localparam logic [STATE_W-1:0] ST_STAND  = 8'b0010_0000;
  localparam logic [STATE_W-1:0] ST_HURT   = 8'b0100_0000;
  localparam logic [STATE_W-1:0] ST_KO     = 8'b1000_0000;

  localparam logic FACE_RIGHT = 1'b0;
  localparam logic FACE_LEFT  = 1'b1;

  // States during which the fighter cannot accept a new idle command.
  function automatic logic is_busy(input logic [STATE_W-1:0] st);
    return (st & (ST_JUMP | ST_PUNCH | ST_HURT | ST_KO)) != '0;
  endfunction

endpackage

// File: rtl/fighter_ctrl_if.sv
// fighter_ctrl_if
//   Bundles the controller's game-facing signals.
//   master : the debouncer/game side (drives buttons and events, reads requests)
//   slave  : the fighter controller
//   Inputs to controller : player_id, left/right/up/down/attack/shield_btn,
//                          hit_in (pulse), health_zero (level)
//   Outputs of controller: attack_request, jump_request (pulses),
//                          left_request, right_request (levels),
//                          action {facing, one-hot state}, busy
interface fighter_ctrl_if;
  import fighter_pkg::*;

  logic                player_id;
  logic                left_btn;
  logic                right_btn;
  logic                up_btn;
  logic                down_btn;
  logic                attack_btn;
  logic                shield_btn;
  logic                hit_in;
  logic                health_zero;
  logic                attack_request;
  logic                jump_request;
  logic                left_request;
  logic                right_request;
  logic [ACTION_W-1:0] action;
  logic                busy;

  modport master (
    output player_id, left_btn, right_btn, up_btn, down_btn,
           attack_btn, shield_btn, hit_in, health_zero,
    input  attack_request, jump_request, left_request, right_request,
           action, busy
  );

  modport slave (
    input  player_id, left_btn, right_btn, up_btn, down_btn,
           attack_btn, shield_btn, hit_in, health_zero,
    output attack_request, jump_request, left_request, right_request,
           action, busy
  );

endinterface

// File: rtl/fighter_ctrl_tick_counter.sv
// tick_counter
//   Loadable down-counter that stops at zero (never wraps).
//   clk, reset  : clock, synchronous active-low reset (clears count)
//   load_i      : load load_val_i this cycle (takes priority over counting)
//   load_val_i  : value to load
//   cnt_o       : current count
//   zero_o      : count is zero
module tick_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fighter_ctrl.sv
// fighter_ctrl
//   Per-player action controller. Turns debounced button levels and game
//   hit/KO events into a one-hot action state plus movement/attack requests.
//   Ports:
//     clk    : system clock
//     reset  : synchronous, active-low reset
//     bus    : fighter_ctrl_if.slave (buttons, hit_in, health_zero in;
//              attack/jump pulses, left/right levels, action, busy out)
//   All outputs are registered and line up with the state they describe.
module fighter_ctrl
  import fighter_pkg::*;
#(
  parameter int             CNT_W          = 24,
  parameter logic [CNT_W-1:0] JUMP_TICKS     = 24'd5000000,
  parameter logic [CNT_W-1:0] PUNCH_TICKS    = 24'd1250000,
  parameter logic [CNT_W-1:0] COOLDOWN_TICKS = 24'd2500000,
  parameter logic [CNT_W-1:0] HITSTUN_TICKS  = 24'd2000000,
  parameter bit               BUFFER_EN      = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  fighter_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] ONE        = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] JUMP_LOAD  = JUMP_TICKS - ONE;
  localparam logic [CNT_W-1:0] PUNCH_LOAD = PUNCH_TICKS - ONE;
  localparam logic [CNT_W-1:0] CD_LOAD    = COOLDOWN_TICKS - ONE;
  localparam logic [CNT_W-1:0] HIT_LOAD   = HITSTUN_TICKS - ONE;
  localparam logic [CNT_W-1:0] JUMP_HALF  = JUMP_TICKS >> 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic               facing_q, facing_d;
  logic               buf_q, buf_d;
  logic               att_prev_q;
  logic               attack_req_q, attack_req_d;
  logic               jump_req_q, jump_req_d;
  logic               left_req_q, left_req_d;
  logic               right_req_q, right_req_d;
  logic               busy_q, busy_d;

  logic               dur_load;
  logic [CNT_W-1:0]   dur_val;
  logic [CNT_W-1:0]   dur_cnt;
  logic               dur_zero;
  logic               cd_load;
  logic [CNT_W-1:0]   cd_cnt_unused;  // cooldown is only consulted as a zero flag
  logic               cd_zero;

  logic               attack_rise;
  logic               freeze_face;
  logic               moving;

  tick_counter #(.CNT_W(CNT_W)) u_dur_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (dur_load),
    .load_val_i (dur_val),
    .cnt_o      (dur_cnt),
    .zero_o     (dur_zero)
  );

  tick_counter #(.CNT_W(CNT_W)) u_cd_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cd_load),
    .load_val_i (CD_LOAD),
    .cnt_o      (cd_cnt_unused),
    .zero_o     (cd_zero)
  );

  // Only a fresh press may launch a punch from idle; a held button never
  // re-triggers even after the cooldown expires.
  assign attack_rise = bus.attack_btn & ~att_prev_q;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    dur_load = 1'b0;
    dur_val  = JUMP_LOAD;
    cd_load  = 1'b0;

    if (state_q == ST_KO) begin
      state_d = ST_KO;
    end else if (bus.health_zero) begin
      state_d = ST_KO;
      buf_d   = 1'b0;
    end else if (bus.hit_in && (state_q != ST_SHIELD)) begin
      // Also reloads hitstun when already hurt.
      state_d  = ST_HURT;
      dur_load = 1'b1;
      dur_val  = HIT_LOAD;
      buf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_HURT, ST_PUNCH: begin
          if (dur_zero)
            state_d = ST_STAND;
        end
        ST_JUMP: begin
          if (dur_zero) begin
            buf_d = 1'b0;
            if (BUFFER_EN && buf_q && cd_zero) begin
              state_d  = ST_PUNCH;
              dur_load = 1'b1;
              dur_val  = PUNCH_LOAD;
              cd_load  = 1'b1;
            end else begin
              state_d = ST_STAND;
            end
          end else if (BUFFER_EN && bus.attack_btn && (dur_cnt < JUMP_HALF)) begin
            buf_d = 1'b1;
          end
        end
        // Idle states; any corrupted code also lands here and recovers.
        default: begin
          if (bus.down_btn) begin
            state_d = ST_CROUCH;
          end else if (bus.left_btn || bus.right_btn) begin
            state_d = ST_WALK;
          end else if (bus.shield_btn) begin
            state_d = ST_SHIELD;
          end else if (bus.up_btn) begin
            state_d  = ST_JUMP;
            dur_load = 1'b1;
            dur_val  = JUMP_LOAD;
          end else if (attack_rise && cd_zero) begin
            state_d  = ST_PUNCH;
            dur_load = 1'b1;
            dur_val  = PUNCH_LOAD;
            cd_load  = 1'b1;
          end else begin
            state_d = ST_STAND;
          end
        end
      endcase
    end
  end

  // Facing holds for the whole hitstun/KO, including the entry and exit edges.
  assign freeze_face = (state_q == ST_HURT) || (state_q == ST_KO) ||
                       (state_d == ST_HURT) || (state_d == ST_KO);
  assign moving      = (state_d == ST_WALK) || (state_d == ST_JUMP);

  always_comb begin
    facing_d = facing_q;
    if (!freeze_face) begin
      if (bus.right_btn)
        facing_d = FACE_RIGHT;
      else if (bus.left_btn)
        facing_d = FACE_LEFT;
    end
    right_req_d  = moving & bus.right_btn;
    left_req_d   = moving & bus.left_btn & ~bus.right_btn;
    jump_req_d   = (state_d == ST_JUMP)  && (state_q != ST_JUMP);
    attack_req_d = (state_d == ST_PUNCH) && (state_q != ST_PUNCH);
    busy_d       = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_STAND;
      facing_q     <= bus.player_id;
      buf_q        <= 1'b0;
      att_prev_q   <= 1'b0;
      attack_req_q <= 1'b0;
      jump_req_q   <= 1'b0;
      left_req_q   <= 1'b0;
      right_req_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      facing_q     <= facing_d;
      buf_q        <= buf_d;
      att_prev_q   <= bus.attack_btn;
      attack_req_q <= attack_req_d;
      jump_req_q   <= jump_req_d;
      left_req_q   <= left_req_d;
      right_req_q  <= right_req_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.action         = {facing_q, state_q};
  assign bus.attack_request = attack_req_q;
  assign bus.jump_request   = jump_req_q;
  assign bus.left_request   = left_req_q;
  assign bus.right_request  = right_req_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_fighter_ctrl.sv
module tb_fighter_ctrl;
  localparam int J  = 8;
  localparam int P  = 4;
  localparam int CD = 10;
  localparam int H  = 6;

  // Action indices in the order of the one-hot bit positions.
  localparam int I_WALK = 0, I_CROUCH = 1, I_SHIELD = 2, I_JUMP = 3;
  localparam int I_PUNCH = 4, I_STAND = 5, I_HURT = 6, I_KO = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fighter_ctrl_if ifc();

  fighter_ctrl #(
    .CNT_W(24), .JUMP_TICKS(24'd8), .PUNCH_TICKS(24'd4),
    .COOLDOWN_TICKS(24'd10), .HITSTUN_TICKS(24'd6), .BUFFER_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;

  // Reference model state
  int m_st, m_dur, m_cd;
  bit m_face, m_buf, m_prev;
  bit m_att, m_jmp, m_l, m_r, m_busy;

  typedef struct {
    logic [5:0] btn;   // {left, right, up, down, attack, shield}
    logic       hit;
    logic       hz;
    logic [8:0] act;
    logic [3:0] req;   // {attack, jump, left, right}
    logic       busy;
  } vec_t;
  vec_t tbl[14];

  task automatic set_in(input logic [5:0] btn, input logic hit, input logic hz);
    {ifc.left_btn, ifc.right_btn, ifc.up_btn, ifc.down_btn,
     ifc.attack_btn, ifc.shield_btn} = btn;
    ifc.hit_in      = hit;
    ifc.health_zero = hz;
  endtask

  function automatic logic [3:0] dut_req();
    return {ifc.attack_request, ifc.jump_request, ifc.left_request, ifc.right_request};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic model_edge();
    int old, nst, nd, nc;
    bit nb, rise, frz, mv;
    if (!reset) begin
      m_st = I_STAND; m_face = ifc.player_id; m_dur = 0; m_cd = 0;
      m_buf = 0; m_prev = 0; m_att = 0; m_jmp = 0; m_l = 0; m_r = 0; m_busy = 0;
      return;
    end
    old  = m_st;
    nst  = old;
    nb   = m_buf;
    nd   = (m_dur > 0) ? m_dur - 1 : 0;
    nc   = (m_cd > 0) ? m_cd - 1 : 0;
    rise = ifc.attack_btn && !m_prev;
    if (old == I_KO) nst = I_KO;
    else if (ifc.health_zero) begin nst = I_KO; nb = 0; end
    else if (ifc.hit_in && old != I_SHIELD) begin nst = I_HURT; nd = H - 1; nb = 0; end
    else if (old == I_HURT || old == I_PUNCH) begin
      if (m_dur == 0) nst = I_STAND;
    end else if (old == I_JUMP) begin
      if (m_dur == 0) begin
        if (m_buf && m_cd == 0) begin nst = I_PUNCH; nd = P - 1; nc = CD - 1; end
        else nst = I_STAND;
        nb = 0;
      end else if (ifc.attack_btn && m_dur < J / 2) nb = 1;
    end else begin
      if (ifc.down_btn) nst = I_CROUCH;
      else if (ifc.left_btn || ifc.right_btn) nst = I_WALK;
      else if (ifc.shield_btn) nst = I_SHIELD;
      else if (ifc.up_btn) begin nst = I_JUMP; nd = J - 1; end
      else if (rise && m_cd == 0) begin nst = I_PUNCH; nd = P - 1; nc = CD - 1; end
      else nst = I_STAND;
    end
    frz = (old == I_HURT) || (old == I_KO) || (nst == I_HURT) || (nst == I_KO);
    if (!frz) begin
      if (ifc.right_btn) m_face = 0;
      else if (ifc.left_btn) m_face = 1;
    end
    mv     = (nst == I_WALK) || (nst == I_JUMP);
    m_r    = mv && ifc.right_btn;
    m_l    = mv && ifc.left_btn && !ifc.right_btn;
    m_jmp  = (nst == I_JUMP) && (old != I_JUMP);
    m_att  = (nst == I_PUNCH) && (old != I_PUNCH);
    m_busy = (nst == I_JUMP) || (nst == I_PUNCH) || (nst == I_HURT) || (nst == I_KO);
    m_st = nst; m_dur = nd; m_cd = nc; m_buf = nb; m_prev = ifc.attack_btn;
  endtask

  task automatic compare_model();
    logic [7:0]  oh;
    logic [13:0] exp_v, got_v;
    oh = '0;
    oh[m_st] = 1'b1;
    exp_v = {m_face, oh, m_att, m_jmp, m_l, m_r, m_busy};
    got_v = {ifc.action, dut_req(), ifc.busy};
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL model @%0t: action/req/busy got %h/%b/%b, expected %h/%b/%b",
                 $time, got_v[13:5], got_v[4:1], got_v[0], exp_v[13:5], exp_v[4:1], exp_v[0]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle(input int n);
    set_in(6'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input logic pid);
    reset = 1'b0;
    ifc.player_id = pid;
    set_in(6'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int c_a, c_b, c_c;

    tbl[0]  = '{6'b000000, 0, 0, 9'h120, 4'b0000, 0};
    tbl[1]  = '{6'b010000, 0, 0, 9'h001, 4'b0001, 0};
    tbl[2]  = '{6'b100000, 0, 0, 9'h101, 4'b0010, 0};
    tbl[3]  = '{6'b110000, 0, 0, 9'h001, 4'b0001, 0};
    tbl[4]  = '{6'b010100, 0, 0, 9'h002, 4'b0000, 0};
    tbl[5]  = '{6'b000001, 0, 0, 9'h004, 4'b0000, 0};
    tbl[6]  = '{6'b000001, 1, 0, 9'h004, 4'b0000, 0};
    tbl[7]  = '{6'b001000, 0, 0, 9'h008, 4'b0100, 1};
    tbl[8]  = '{6'b000000, 0, 0, 9'h008, 4'b0000, 1};
    tbl[9]  = '{6'b100000, 0, 0, 9'h108, 4'b0010, 1};
    tbl[10] = '{6'b000000, 1, 0, 9'h140, 4'b0000, 1};
    tbl[11] = '{6'b010000, 0, 0, 9'h140, 4'b0000, 1};
    tbl[12] = '{6'b000000, 0, 1, 9'h180, 4'b0000, 1};
    tbl[13] = '{6'b011010, 0, 0, 9'h180, 4'b0000, 1};

    // Reset state with player 1 (faces left)
    do_reset(1'b1);
    chk("reset_action_p1", {23'd0, ifc.action}, 32'h120);
    chk("reset_req_busy", {27'd0, dut_req(), ifc.busy}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].btn, tbl[i].hit, tbl[i].hz);
      tick();
      chk($sformatf("tbl%0d_action", i), {23'd0, ifc.action}, {23'd0, tbl[i].act});
      chk($sformatf("tbl%0d_req", i), {28'd0, dut_req()}, {28'd0, tbl[i].req});
      chk($sformatf("tbl%0d_busy", i), {31'd0, ifc.busy}, {31'd0, tbl[i].busy});
    end

    do_reset(1'b0);
    chk("reset_action_p0", {23'd0, ifc.action}, 32'h020);

    // Single jump: one jump_request, eight JUMP cycles, busy throughout
    c_a = 0; c_b = 0; c_c = 0;
    set_in(6'b001000, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) set_in(6'b0, 0, 0);
      c_a += ifc.jump_request;
      c_b += ifc.action[I_JUMP];
      c_c += ifc.busy;
    end
    chk("jump_pulses", c_a, 1);
    chk("jump_cycles", c_b, J);
    chk("jump_busy_cycles", c_c, J);
    chk("jump_lands_stand", {23'd0, ifc.action}, 32'h020);

    // Attack held 30 cycles: one pulse, four PUNCH cycles
    c_a = 0; c_b = 0;
    set_in(6'b000010, 0, 0);
    for (int i = 0; i < 30; i++) begin
      tick();
      c_a += ifc.attack_request;
      c_b += ifc.action[I_PUNCH];
    end
    chk("held_attack_pulses", c_a, 1);
    chk("punch_cycles", c_b, P);

    // Cooldown gating
    idle(12);
    c_a = 0;
    set_in(6'b000010, 0, 0); tick(); c_a += ifc.attack_request;
    set_in(6'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin tick(); c_a += ifc.attack_request; end
    chk("fresh_press_pulse", c_a, 1);
    c_a = 0;
    set_in(6'b000010, 0, 0); tick(); c_a += ifc.attack_request;
    set_in(6'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin tick(); c_a += ifc.attack_request; end
    chk("cooldown_blocks", c_a, 0);
    idle(3);
    c_a = 0;
    set_in(6'b000010, 0, 0); tick(); c_a += ifc.attack_request;
    set_in(6'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin tick(); c_a += ifc.attack_request; end
    chk("after_cooldown_pulse", c_a, 1);

    // Buffered attack at jump cycle 6 fires on landing
    idle(12);
    set_in(6'b001000, 0, 0); tick();
    idle(5);
    set_in(6'b000010, 0, 0); tick();
    idle(2);
    chk("buffer_punch_state", {23'd0, ifc.action}, 32'h010);
    chk("buffer_attack_pulse", {31'd0, ifc.attack_request}, 32'd1);
    idle(15);

    // Hit during walk: six HURT cycles, no movement while hurt
    c_a = 0; c_b = 0;
    set_in(6'b010000, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    set_in(6'b010000, 1, 0); tick();
    c_a += ifc.action[I_HURT]; c_b += ifc.action[I_HURT] & (ifc.left_request | ifc.right_request);
    set_in(6'b010000, 0, 0);
    for (int i = 0; i < 19; i++) begin
      tick();
      c_a += ifc.action[I_HURT]; c_b += ifc.action[I_HURT] & (ifc.left_request | ifc.right_request);
    end
    chk("hurt_cycles", c_a, H);
    chk("hurt_walk_resumes", {23'd0, ifc.action}, 32'h001);

    // Re-hit on HURT cycle 3 extends hitstun by a full period
    c_a = 0;
    for (int i = 0; i < 20; i++) begin
      set_in(6'b010000, (i == 0 || i == 3), 0);
      tick();
      c_a += ifc.action[I_HURT]; c_b += ifc.action[I_HURT] & (ifc.left_request | ifc.right_request);
    end
    chk("rehit_cycles", c_a, 3 + H);
    chk("hurt_no_move", c_b, 0);

    // Hit while shielding is ignored
    set_in(6'b000001, 0, 0); tick(); tick();
    set_in(6'b000001, 1, 0); tick();
    chk("shield_ignores_hit", {23'd0, ifc.action[7:0]}, 32'h004);
    chk("shield_not_busy", {31'd0, ifc.busy}, 32'd0);
    idle(2);

    // Reset in the middle of a jump
    set_in(6'b001000, 0, 0); tick();
    idle(2);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("midjump_reset", {23'd0, ifc.action}, 32'h020);
    chk("midjump_reset_busy", {31'd0, ifc.busy}, 32'd0);

    // KO is sticky regardless of inputs
    c_a = 0;
    set_in(6'b0, 1, 1); tick(); c_a += ifc.action[I_KO];
    for (int i = 0; i < 20; i++) begin
      set_in(6'($urandom), 1'($urandom), 1'b0);
      tick();
      c_a += ifc.action[I_KO] & ifc.busy;
    end
    chk("ko_sticky", c_a, 21);
    do_reset(1'b1);

    // Random stimulus against the reference model
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] b;
      for (int k = 0; k < 6; k++) b[k] = ($urandom_range(0, 3) == 0);
      set_in(b, ($urandom_range(0, 39) == 0), ($urandom_range(0, 799) == 0));
      ifc.player_id = 1'($urandom);
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
